dbg_uart_rx: RTL

DBG_UART_RX -- requirements
Module: dbg_uart_rx

---
 rtl/panda_uart_pkg.sv | 17 +
 rtl/uart_tick_gen.sv | 26 ++
 rtl/dbg_uart_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/panda_uart_pkg.sv
// Shared constants and state encoding for the debug UART receiver.
package panda_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned SAMPLE_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one tick every CLK_DIV cycles, restartable so
// ticks line up with a detected start edge.
module uart_tick_gen #(
  parameter int unsigned CLK_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned DIV_W = 16;

  logic [DIV_W-1:0] cnt;

  assign tick_c = (cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dbg_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a one-byte output buffer with
// valid/ready handshake, and frame-error / overrun pulses.
module dbg_uart_rx
  import panda_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 54
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam logic [SAMPLE_W-1:0] MID_SAMPLE  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]    LAST_BIT    = BIT_W'(DATA_BITS - 1);

  logic rx_meta;
  logic rx_s;

  rx_state_e            state,      state_n;
  logic [SAMPLE_W-1:0]  sample_cnt, sample_n;
  logic [BIT_W-1:0]     bit_idx,    bit_n;
  logic [DATA_BITS-1:0] shift,      shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 frame_err_n;
  logic                 overrun_n;
  logic                 restart_c;
  logic                 done_c;
  logic                 tick_c;

  uart_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (sys_clk_i),
    .rst     (rst_i),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_n     = state;
    sample_n    = sample_cnt;
    bit_n       = bit_idx;
    shift_n     = shift;
    data_n      = data_o;
    valid_n     = valid_o;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    restart_c   = 1'b0;
    done_c      = 1'b0;

    if (valid_o && ready_i) begin
      valid_n = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n   = ST_START;
          sample_n  = '0;
          restart_c = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (sample_cnt == MID_SAMPLE) begin
            // A line already back high at mid start bit was a glitch
            if (rx_s) begin
              state_n = ST_IDLE;
            end else begin
              state_n  = ST_DATA;
              sample_n = '0;
              bit_n    = '0;
            end
          end else begin
            sample_n = sample_cnt + SAMPLE_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (sample_cnt == LAST_SAMPLE) begin
            sample_n = '0;
            shift_n  = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state_n = ST_STOP;
            end else begin
              bit_n = bit_idx + BIT_W'(1);
            end
          end else begin
            sample_n = sample_cnt + SAMPLE_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (sample_cnt == LAST_SAMPLE) begin
            sample_n = '0;
            if (rx_s) begin
              state_n = ST_IDLE;
              done_c  = 1'b1;
            end else begin
              state_n     = ST_WAIT_HIGH;
              frame_err_n = 1'b1;
            end
          end else begin
            sample_n = sample_cnt + SAMPLE_W'(1);
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // A completed byte may replace the buffered one only if it is consumed now
    if (done_c) begin
      if (!valid_o || ready_i) begin
        data_n  = shift;
        valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= ST_IDLE;
      sample_cnt  <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_meta     <= rx_i;
      rx_s        <= rx_meta;
      state       <= state_n;
      sample_cnt  <= sample_n;
      bit_idx     <= bit_n;
      shift       <= shift_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= frame_err_n;
      overrun_o   <= overrun_n;
    end
  end

endmodule
